// File: rtl/tap_pkg.sv
// Shared TAP definitions: the 16 controller states in their IEEE 1149.1
// encodings, plus small decode helpers used by the controller and by any
// instruction/data register logic that needs to interpret the state.
package tap_pkg;

    localparam int unsigned TAP_STATE_W = 4;

    typedef enum logic [TAP_STATE_W-1:0] {
        TAP_EX2DR   = 4'h0,
        TAP_EX1DR   = 4'h1,
        TAP_SHDR    = 4'h2,
        TAP_PAUSEDR = 4'h3,
        TAP_SELIR   = 4'h4,
        TAP_UPDDR   = 4'h5,
        TAP_CAPDR   = 4'h6,
        TAP_SELDR   = 4'h7,
        TAP_EX2IR   = 4'h8,
        TAP_EX1IR   = 4'h9,
        TAP_SHIR    = 4'hA,
        TAP_PAUSEIR = 4'hB,
        TAP_RTI     = 4'hC,
        TAP_UPDIR   = 4'hD,
        TAP_CAPIR   = 4'hE,
        TAP_TLR     = 4'hF
    } tap_state_t;

    // True for every state from Select-IR-Scan down to Update-IR.
    function automatic logic in_ir_column(input tap_state_t s);
        logic r;
        r = 1'b0;
        case (s)
            TAP_SELIR, TAP_CAPIR, TAP_SHIR, TAP_EX1IR,
            TAP_PAUSEIR, TAP_EX2IR, TAP_UPDIR: r = 1'b1;
            default:                           r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tap_controller.sv
// JTAG TAP controller: 16-state Moore FSM clocked by tck. All outputs are
// decoded from the registered state only, so none of them follows tms
// combinationally.
module tap_controller
    import tap_pkg::*;
(
    input  logic       tck,
    input  logic       reset,
    input  logic       tms,
    output logic       tl_reset,
    output logic       captureIR,
    output logic       shiftIR,
    output logic       updateIR,
    output logic       captureDR,
    output logic       shiftDR,
    output logic       updateDR,
    output logic       ir_clk_en,
    output logic       dr_clk_en,
    output logic       select_ir,
    output logic       tdo_en,
    output logic [3:0] state
);

    tap_state_t state_q;
    tap_state_t state_d;

    // State register; reset wins over any tms value in the same cycle.
    always_ff @(posedge tck) begin
        if (reset) begin
            state_q <= TAP_TLR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection from the current state and tms.
    always_comb begin
        state_d = TAP_TLR;
        case (state_q)
            TAP_TLR:     state_d = tms ? TAP_TLR   : TAP_RTI;
            TAP_RTI:     state_d = tms ? TAP_SELDR : TAP_RTI;
            TAP_SELDR:   state_d = tms ? TAP_SELIR : TAP_CAPDR;
            TAP_CAPDR:   state_d = tms ? TAP_EX1DR : TAP_SHDR;
            TAP_SHDR:    state_d = tms ? TAP_EX1DR : TAP_SHDR;
            TAP_EX1DR:   state_d = tms ? TAP_UPDDR : TAP_PAUSEDR;
            TAP_PAUSEDR: state_d = tms ? TAP_EX2DR : TAP_PAUSEDR;
            TAP_EX2DR:   state_d = tms ? TAP_UPDDR : TAP_SHDR;
            TAP_UPDDR:   state_d = tms ? TAP_SELDR : TAP_RTI;
            TAP_SELIR:   state_d = tms ? TAP_TLR   : TAP_CAPIR;
            TAP_CAPIR:   state_d = tms ? TAP_EX1IR : TAP_SHIR;
            TAP_SHIR:    state_d = tms ? TAP_EX1IR : TAP_SHIR;
            TAP_EX1IR:   state_d = tms ? TAP_UPDIR : TAP_PAUSEIR;
            TAP_PAUSEIR: state_d = tms ? TAP_EX2IR : TAP_PAUSEIR;
            TAP_EX2IR:   state_d = tms ? TAP_UPDIR : TAP_SHIR;
            TAP_UPDIR:   state_d = tms ? TAP_SELDR : TAP_RTI;
            // Any encoding not listed above falls back to Test-Logic-Reset.
            default:     state_d = TAP_TLR;
        endcase
    end

    // Output decode from the state register alone.
    always_comb begin
        tl_reset  = (state_q != TAP_TLR);
        captureIR = (state_q == TAP_CAPIR);
        shiftIR   = (state_q == TAP_SHIR);
        updateIR  = (state_q == TAP_UPDIR);
        captureDR = (state_q == TAP_CAPDR);
        shiftDR   = (state_q == TAP_SHDR);
        updateDR  = (state_q == TAP_UPDDR);
        ir_clk_en = captureIR | shiftIR;
        dr_clk_en = captureDR | shiftDR;
        select_ir = in_ir_column(state_q);
        tdo_en    = shiftIR | shiftDR;
        state     = state_q;
    end

endmodule

// File: tb/tb_tap_controller.sv
// Randomized and directed bench for tap_controller. A driver issues tms/reset
// on the falling edge and pushes the expected post-edge outputs (from a
// table-driven reference model) into a queue; a monitor pops and compares
// just after each rising edge.
module tb_tap_controller;

    logic       tck;
    logic       reset;
    logic       tms;
    logic       tl_reset;
    logic       captureIR, shiftIR, updateIR;
    logic       captureDR, shiftDR, updateDR;
    logic       ir_clk_en, dr_clk_en, select_ir, tdo_en;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;

    // strobe counters observed by the monitor, cleared by the directed tests
    int n_capir, n_shir, n_updir, n_capdr, n_shdr, n_upddr;

    logic [14:0] expq[$];
    logic [3:0]  model_s;
    logic [3:0]  nxt0 [16];
    logic [3:0]  nxt1 [16];

    tap_controller dut (
        .tck       (tck),
        .reset     (reset),
        .tms       (tms),
        .tl_reset  (tl_reset),
        .captureIR (captureIR),
        .shiftIR   (shiftIR),
        .updateIR  (updateIR),
        .captureDR (captureDR),
        .shiftDR   (shiftDR),
        .updateDR  (updateDR),
        .ir_clk_en (ir_clk_en),
        .dr_clk_en (dr_clk_en),
        .select_ir (select_ir),
        .tdo_en    (tdo_en),
        .state     (state)
    );

    initial tck = 1'b0;
    always #5 tck = ~tck;

    // Expected output vector for a given state, from the outputs' definitions.
    function automatic logic [14:0] exp_vec(input logic [3:0] s);
        logic tlr, cir, sir, uir, cdr, sdr, udr, col;
        tlr = (s == 4'hF);
        cir = (s == 4'hE);
        sir = (s == 4'hA);
        uir = (s == 4'hD);
        cdr = (s == 4'h6);
        sdr = (s == 4'h2);
        udr = (s == 4'h5);
        col = (s inside {4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD});
        return {s, ~tlr, cir, sir, uir, cdr, sdr, udr,
                cir | sir, cdr | sdr, col, sir | sdr};
    endfunction

    function automatic logic [14:0] dut_vec();
        return {state, tl_reset, captureIR, shiftIR, updateIR, captureDR, shiftDR,
                updateDR, ir_clk_en, dr_clk_en, select_ir, tdo_en};
    endfunction

    // One tck cycle of stimulus with its expected result queued.
    task automatic step(input logic t, input logic r);
        @(negedge tck);
        tms   = t;
        reset = r;
        if (r) model_s = 4'hF;
        else   model_s = t ? nxt1[model_s] : nxt0[model_s];
        expq.push_back(exp_vec(model_s));
    endtask

    task automatic clear_counts();
        n_capir = 0; n_shir = 0; n_updir = 0;
        n_capdr = 0; n_shdr = 0; n_upddr = 0;
    endtask

    task automatic check_int(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Let the last queued edge happen and the monitor consume it.
    task automatic settle();
        @(posedge tck);
        #2;
    endtask

    // Monitor: compare every presented output vector against the queue head.
    always @(posedge tck) begin
        #1;
        if (expq.size() > 0) begin
            logic [14:0] e;
            logic [14:0] a;
            int hot;
            e = expq.pop_front();
            a = dut_vec();
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL outputs: got %h (state %h), expected %h (state %h)",
                         a, a[14:11], e, e[14:11]);
            end
            hot = int'(captureIR) + int'(shiftIR) + int'(updateIR)
                + int'(captureDR) + int'(shiftDR) + int'(updateDR);
            total++;
            if (hot > 1) begin
                bad++;
                $display("FAIL exclusive: got %0d strobes high, expected at most 1", hot);
            end
            n_capir += int'(captureIR);
            n_shir  += int'(shiftIR);
            n_updir += int'(updateIR);
            n_capdr += int'(captureDR);
            n_shdr  += int'(shiftDR);
            n_upddr += int'(updateDR);
        end
    end

    initial begin
        logic [3:0] seq_ir [9];
        logic [3:0] seq_dr [10];
        int steps;

        // reference transition table: index = state, value = next state
        nxt1[4'hF] = 4'hF; nxt0[4'hF] = 4'hC;
        nxt1[4'hC] = 4'h7; nxt0[4'hC] = 4'hC;
        nxt1[4'h7] = 4'h4; nxt0[4'h7] = 4'h6;
        nxt1[4'h6] = 4'h1; nxt0[4'h6] = 4'h2;
        nxt1[4'h2] = 4'h1; nxt0[4'h2] = 4'h2;
        nxt1[4'h1] = 4'h5; nxt0[4'h1] = 4'h3;
        nxt1[4'h3] = 4'h0; nxt0[4'h3] = 4'h3;
        nxt1[4'h0] = 4'h5; nxt0[4'h0] = 4'h2;
        nxt1[4'h5] = 4'h7; nxt0[4'h5] = 4'hC;
        nxt1[4'h4] = 4'hF; nxt0[4'h4] = 4'hE;
        nxt1[4'hE] = 4'h9; nxt0[4'hE] = 4'hA;
        nxt1[4'hA] = 4'h9; nxt0[4'hA] = 4'hA;
        nxt1[4'h9] = 4'hD; nxt0[4'h9] = 4'hB;
        nxt1[4'hB] = 4'h8; nxt0[4'hB] = 4'hB;
        nxt1[4'h8] = 4'hD; nxt0[4'h8] = 4'hA;
        nxt1[4'hD] = 4'h7; nxt0[4'hD] = 4'hC;

        model_s = 4'hF;
        reset   = 1'b1;
        tms     = 1'b0;
        clear_counts();

        // reset, then one tms=0 cycle to Run-Test/Idle
        step(1'b0, 1'b1);
        settle();
        check_int("reset_state", int'(state), 15);
        check_int("reset_tl_reset", int'(tl_reset), 0);
        step(1'b0, 1'b0);
        settle();
        check_int("rti_state", int'(state), 12);
        check_int("rti_tl_reset", int'(tl_reset), 1);

        // IR scan from RTI
        seq_ir = '{4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd0};
        clear_counts();
        foreach (seq_ir[i]) step(seq_ir[i][0], 1'b0);
        settle();
        check_int("ir_capture_cycles", n_capir, 1);
        check_int("ir_shift_cycles", n_shir, 3);
        check_int("ir_update_cycles", n_updir, 1);
        check_int("ir_end_state", int'(state), 12);

        // DR scan with pause from RTI
        seq_dr = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd1, 4'd0, 4'd1, 4'd1};
        clear_counts();
        foreach (seq_dr[i]) step(seq_dr[i][0], 1'b0);
        settle();
        check_int("dr_capture_cycles", n_capdr, 1);
        check_int("dr_shift_cycles", n_shdr, 3);
        check_int("dr_update_cycles", n_upddr, 1);
        check_int("dr_end_state", int'(state), 5);

        // five tms=1 cycles from every state reach Test-Logic-Reset
        for (int tgt = 0; tgt < 16; tgt++) begin
            step(1'b0, 1'b1);
            steps = 0;
            while (model_s != tgt[3:0] && steps < 400) begin
                step(1'($urandom_range(0, 1)), 1'b0);
                steps++;
            end
            check_int($sformatf("reach_state_%0h", tgt), int'(model_s), tgt);
            repeat (5) step(1'b1, 1'b0);
            settle();
            check_int($sformatf("five_ones_from_%0h", tgt), int'(state), 15);
            check_int($sformatf("five_ones_tl_reset_%0h", tgt), int'(tl_reset), 0);
        end

        // reset during Shift-DR aborts without an update strobe
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        settle();
        check_int("in_shift_dr", int'(state), 2);
        clear_counts();
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        settle();
        check_int("abort_update_dr", n_upddr, 0);
        check_int("abort_state", int'(state), 12);

        // reset and tms=1 together: reset wins
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        settle();
        check_int("reset_priority", int'(state), 15);

        // random tms (occasional reset) checked every cycle by the monitor
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));
        end
        step(1'b0, 1'b0);

        steps = 0;
        while (expq.size() > 0 && steps < 20) begin
            @(negedge tck);
            steps++;
        end
        if (expq.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending, expected 0", expq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
